jump_game_sequencer: RTL and testbench

- Top-level game-flow controller for the obstacle game. Sequences the player jump datapath, scores cleared obstacles, detects collisions and drives the win "falling square" animation.
- Sits between the debounced jump button, the obstacle generator and the jump datapath (jump_en → en, falling_sq → fallingSq, height ← out). Also feeds the VGA/score display.

---
 rtl/jump_game_sequencer.sv | 140 ++++++++++++++
 tb/tb_jump_game_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/jump_game_sequencer.sv
// jump_game_sequencer: game-flow controller for the obstacle game.
// It starts and stops the obstacle generator, issues jump requests to the
// jump datapath, counts cleared obstacles, detects collisions and runs the
// win "falling square" animation.
module jump_game_sequencer #(
  parameter logic [9:0] PLAYER_X   = 10'd100,
  parameter logic [9:0] PLAYER_W   = 10'd16,
  parameter logic [9:0] OBS_W      = 10'd16,
  parameter logic [9:0] OBS_H      = 10'd32,
  parameter logic [7:0] WIN_SCORE  = 8'd10,
  parameter logic [3:0] COOLDOWN   = 4'd4,
  parameter logic [5:0] FALL_TICKS = 6'd30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn,
  input  logic       jump_active,
  input  logic [9:0] height,
  input  logic [9:0] obs_x,
  input  logic       obs_wrap,
  output logic       jump_en,
  output logic       falling_sq,
  output logic       obs_run,
  output logic [7:0] score,
  output logic [2:0] state_o,
  output logic       win,
  output logic       lose
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PLAY     = 3'd1;
  localparam logic [2:0] S_WIN_FALL = 3'd2;
  localparam logic [2:0] S_WON      = 3'd3;
  localparam logic [2:0] S_LOST     = 3'd4;

  logic [2:0]  state, state_nx;
  logic [7:0]  score_nx;
  logic [3:0]  cooldown, cooldown_nx;
  logic [5:0]  fall_cnt, fall_cnt_nx;
  logic        btn_q;
  logic        rise;
  logic        jump_nx;
  logic        collision;
  logic [10:0] obs_right;
  logic [10:0] player_right;
  logic [7:0]  score_inc;

  // Button edge and collision geometry; widened to 11 bits so the sums never wrap.
  always_comb begin
    rise         = btn & ~btn_q;
    obs_right    = {1'b0, obs_x} + {1'b0, OBS_W};
    player_right = {1'b0, PLAYER_X} + {1'b0, PLAYER_W};
    collision    = (state == S_PLAY) &&
                   (obs_right > {1'b0, PLAYER_X}) &&
                   ({1'b0, obs_x} < player_right) &&
                   (height < OBS_H);
    score_inc    = score + 8'd1;
  end

  // Next-state, score, cooldown and animation counter.
  always_comb begin
    state_nx    = state;
    score_nx    = score;
    cooldown_nx = cooldown;
    fall_cnt_nx = fall_cnt;
    jump_nx     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise) begin
          state_nx    = S_PLAY;
          score_nx    = 8'd0;
          cooldown_nx = 4'd0;
        end
      end
      S_PLAY: begin
        // Collision outranks a same-cycle wrap: the obstacle was hit, not cleared.
        if (tick && collision) begin
          state_nx = S_LOST;
        end else if (obs_wrap) begin
          score_nx = score_inc;
          if (score_inc == WIN_SCORE) begin
            state_nx    = S_WIN_FALL;
            fall_cnt_nx = 6'd0;
          end
        end
        // A jump is only issued if we stay in PLAY, so the registered pulse
        // never shows up in another state. Blocked presses are dropped.
        if (rise && !jump_active && cooldown == 4'd0 && state_nx == S_PLAY) begin
          jump_nx     = 1'b1;
          cooldown_nx = COOLDOWN;
        end else if (tick && cooldown != 4'd0) begin
          cooldown_nx = cooldown - 4'd1;
        end
      end
      S_WIN_FALL: begin
        if (tick) begin
          if (fall_cnt == FALL_TICKS - 6'd1) state_nx = S_WON;
          else                               fall_cnt_nx = fall_cnt + 6'd1;
        end
      end
      S_WON: begin
        if (rise) state_nx = S_IDLE;
      end
      S_LOST: begin
        if (rise) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State registers; btn_q resets high so a button held through reset is not a press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      score    <= 8'd0;
      cooldown <= 4'd0;
      fall_cnt <= 6'd0;
      jump_en  <= 1'b0;
      btn_q    <= 1'b1;
    end else begin
      state    <= state_nx;
      score    <= score_nx;
      cooldown <= cooldown_nx;
      fall_cnt <= fall_cnt_nx;
      jump_en  <= jump_nx;
      btn_q    <= btn;
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    state_o    = state;
    obs_run    = (state == S_PLAY);
    falling_sq = (state == S_WIN_FALL);
    win        = (state == S_WON);
    lose       = (state == S_LOST);
  end

endmodule

// File: tb/tb_jump_game_sequencer.sv
// Self-checking bench for jump_game_sequencer (WIN_SCORE overridden to 3).
module tb_jump_game_sequencer;

  logic       clk = 1'b0;
  logic       reset, tick, btn, jump_active, obs_wrap;
  logic [9:0] height, obs_x;
  logic       jump_en, falling_sq, obs_run, win, lose;
  logic [7:0] score;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected jump_en and score values queued when stimulus is driven.
  logic       exp_jq[$];
  logic [7:0] exp_sq[$];
  logic [7:0] model_score;

  jump_game_sequencer #(.WIN_SCORE(8'd3)) dut (
    .clk(clk), .reset(reset), .tick(tick), .btn(btn), .jump_active(jump_active),
    .height(height), .obs_x(obs_x), .obs_wrap(obs_wrap), .jump_en(jump_en),
    .falling_sq(falling_sq), .obs_run(obs_run), .score(score), .state_o(state_o),
    .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic step_tick();
    tick = 1'b1; cyc(); tick = 1'b0;
  endtask

  task automatic rise_btn();
    btn = 1'b1; cyc(); btn = 1'b0; cyc();
  endtask

  // Press and hold for one edge; the expected jump_en is queued for the caller.
  task automatic press(input logic e);
    btn = 1'b1; exp_jq.push_back(e); cyc();
  endtask

  task automatic wrap();
    obs_wrap = 1'b1; model_score = model_score + 8'd1; exp_sq.push_back(model_score);
    cyc(); obs_wrap = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    reset = 0; btn = 1; tick = 0; jump_active = 0; height = 0; obs_x = 10'd500; obs_wrap = 0;
    repeat (3) cyc();
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
    checks++; if ({jump_en, falling_sq, obs_run, win, lose} !== 5'b0) begin errors++;
      $display("FAIL reset_outputs got %b exp 00000", {jump_en, falling_sq, obs_run, win, lose}); end
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score got %0d exp 0", score); end
    reset = 1; repeat (3) cyc();
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL held_btn_no_start got %0d exp 0", state_o); end
    btn = 0; cyc(); btn = 1; cyc();
    model_score = 0; exp_sq.push_back(8'd0);
    checks++; if (state_o !== 3'd1 || obs_run !== 1'b1) begin errors++;
      $display("FAIL start_play got state %0d run %b exp 1 1", state_o, obs_run); end
    e = exp_sq.pop_front();
    checks++; if (score !== e) begin errors++; $display("FAIL start_score got %0d exp %0d", score, e); end
    checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL start_no_jump got %b exp 0", jump_en); end
    btn = 0; cyc();
  endtask

  task automatic test_jump_cooldown();
    logic e;
    press(1'b1); e = exp_jq.pop_front();
    checks++; if (jump_en !== e) begin errors++; $display("FAIL jump_first got %b exp %b", jump_en, e); end
    btn = 0; cyc();
    checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL jump_one_cycle got %b exp 0", jump_en); end
    repeat (2) step_tick();
    press(1'b0); e = exp_jq.pop_front();
    checks++; if (jump_en !== e) begin errors++; $display("FAIL jump_cooldown_block got %b exp %b", jump_en, e); end
    btn = 0; cyc();
    repeat (2) step_tick();
    press(1'b1); e = exp_jq.pop_front();
    checks++; if (jump_en !== e) begin errors++; $display("FAIL jump_after_cooldown got %b exp %b", jump_en, e); end
    btn = 0; cyc();
    repeat (4) step_tick();
  endtask

  task automatic test_jump_active();
    logic e;
    jump_active = 1;
    press(1'b0); e = exp_jq.pop_front();
    checks++; if (jump_en !== e) begin errors++; $display("FAIL jump_while_active got %b exp %b", jump_en, e); end
    btn = 0; cyc(); jump_active = 0;
    repeat (3) cyc();
    checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL jump_not_queued got %b exp 0", jump_en); end
    press(1'b1); e = exp_jq.pop_front();
    checks++; if (jump_en !== e) begin errors++; $display("FAIL jump_after_active got %b exp %b", jump_en, e); end
    btn = 0; cyc();
    repeat (4) step_tick();
  endtask

  task automatic test_collision();
    logic [7:0] e;
    wrap(); e = exp_sq.pop_front();
    checks++; if (score !== e) begin errors++; $display("FAIL wrap_score got %0d exp %0d", score, e); end
    obs_x = 10'd95; height = 10'd40; step_tick();
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL clear_high got %0d exp 1", state_o); end
    height = 10'd10; step_tick();
    obs_x = 10'd500; height = 10'd0;
    checks++; if (state_o !== 3'd4 || lose !== 1'b1 || obs_run !== 1'b0) begin errors++;
      $display("FAIL collide_lost got state %0d lose %b run %b exp 4 1 0", state_o, lose, obs_run); end
    checks++; if (score !== model_score) begin errors++; $display("FAIL lost_score_held got %0d exp %0d", score, model_score); end
    rise_btn();
    checks++; if (state_o !== 3'd0 || jump_en !== 1'b0) begin errors++;
      $display("FAIL lost_to_idle got state %0d jump %b exp 0 0", state_o, jump_en); end
    rise_btn(); model_score = 0;
    checks++; if (state_o !== 3'd1 || score !== 8'd0) begin errors++;
      $display("FAIL replay got state %0d score %0d exp 1 0", state_o, score); end
  endtask

  task automatic test_win();
    logic [7:0] e;
    logic j;
    for (int i = 0; i < 3; i++) begin
      wrap(); e = exp_sq.pop_front();
      checks++; if (score !== e) begin errors++; $display("FAIL win_wrap%0d got %0d exp %0d", i, score, e); end
    end
    checks++; if (state_o !== 3'd2 || falling_sq !== 1'b1 || obs_run !== 1'b0) begin errors++;
      $display("FAIL win_fall got state %0d fall %b run %b exp 2 1 0", state_o, falling_sq, obs_run); end
    press(1'b0); j = exp_jq.pop_front();
    checks++; if (jump_en !== j || state_o !== 3'd2) begin errors++;
      $display("FAIL fall_btn_ignored got jump %b state %0d exp %b 2", jump_en, state_o, j); end
    btn = 0; cyc();
    repeat (29) step_tick();
    checks++; if (state_o !== 3'd2 || falling_sq !== 1'b1) begin errors++;
      $display("FAIL fall_29 got state %0d fall %b exp 2 1", state_o, falling_sq); end
    step_tick();
    checks++; if (state_o !== 3'd3 || win !== 1'b1 || falling_sq !== 1'b0) begin errors++;
      $display("FAIL won got state %0d win %b fall %b exp 3 1 0", state_o, win, falling_sq); end
    rise_btn();
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL won_to_idle got %0d exp 0", state_o); end
    rise_btn(); model_score = 0;
    checks++; if (state_o !== 3'd1 || score !== 8'd0) begin errors++;
      $display("FAIL win_replay got state %0d score %0d exp 1 0", state_o, score); end
  endtask

  task automatic test_coincident();
    repeat (2) begin wrap(); void'(exp_sq.pop_front()); end
    obs_x = 10'd95; height = 10'd10; obs_wrap = 1; tick = 1; cyc();
    obs_wrap = 0; tick = 0; obs_x = 10'd500; height = 10'd0;
    checks++; if (state_o !== 3'd4 || score !== model_score) begin errors++;
      $display("FAIL coincident got state %0d score %0d exp 4 %0d", state_o, score, model_score); end
    rise_btn();
  endtask

  task automatic test_reset_mid();
    logic e;
    rise_btn(); model_score = 0;
    reset = 0; press(1'b0); e = exp_jq.pop_front();
    checks++; if (jump_en !== e || state_o !== 3'd0) begin errors++;
      $display("FAIL reset_kills_jump got jump %b state %0d exp %b 0", jump_en, state_o, e); end
    reset = 1; btn = 0; cyc();
    rise_btn();
    repeat (3) begin wrap(); void'(exp_sq.pop_front()); end
    repeat (5) step_tick();
    checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL pre_reset_fall got %0d exp 2", state_o); end
    reset = 0; cyc();
    checks++; if (state_o !== 3'd0 || falling_sq !== 1'b0) begin errors++;
      $display("FAIL reset_mid_fall got state %0d fall %b exp 0 0", state_o, falling_sq); end
    reset = 1; cyc();
  endtask

  initial begin
    test_reset();
    test_jump_cooldown();
    test_jump_active();
    test_collision();
    test_win();
    test_coincident();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
